// File: rtl/slow_sched.sv
// ---------------------------------------------------------------------------
// slow_sched
//
// Sequences the accelerator's drop to native-speed bus timing around
// accesses to slow peripherals.  A new bus cycle that selects a device whose
// slow-enable bit is set requests the slow clock from the clock-switch logic
// and stalls the bus cycle until the switch is acknowledged.  After the
// access, slow mode is held for SlowTimeout << HOLD_SHIFT timebase ticks so
// that back-to-back slow accesses do not bounce the clock.
//
// Ports
//   CLK            fast system clock, rising edge
//   nPOR           asynchronous active-low reset
//   BACT           bus cycle active
//   *CS            device selects (IACK, VIA, IWM, SCC, SCSI, sound write)
//   Slow*          per-device slow enables
//   SlowClockGate  permits fast-clock gating while slow
//   SlowTimeout    hold length in units of 2^HOLD_SHIFT ticks, 0 = no hold
//   TimeoutTick    one-CLK pulse from the free-running timebase
//   SlowAck        clock switch reports slow clock in effect
//   SlowReq        request slow clock
//   SlowWait       stall the current bus cycle (hold off DTACK)
//   SlowGate       gate the fast clock
//   HoldCnt        remaining hold ticks (debug)
// ---------------------------------------------------------------------------
module slow_sched #(
    parameter int HOLD_SHIFT = 4,
    parameter int CNTW       = 8
) (
    input  logic            CLK,
    input  logic            nPOR,
    input  logic            BACT,
    input  logic            IACKCS,
    input  logic            VIACS,
    input  logic            IWMCS,
    input  logic            SCCCS,
    input  logic            SCSICS,
    input  logic            SndCSWR,
    input  logic            SlowIACK,
    input  logic            SlowVIA,
    input  logic            SlowIWM,
    input  logic            SlowSCC,
    input  logic            SlowSCSI,
    input  logic            SlowSnd,
    input  logic            SlowClockGate,
    input  logic [3:0]      SlowTimeout,
    input  logic            TimeoutTick,
    input  logic            SlowAck,
    output logic            SlowReq,
    output logic            SlowWait,
    output logic            SlowGate,
    output logic [CNTW-1:0] HoldCnt
);

    if (CNTW != 4 + HOLD_SHIFT) begin : g_bad_cntw
        $error("slow_sched: CNTW must equal 4 + HOLD_SHIFT");
    end

    typedef enum logic [1:0] {
        ST_FAST   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              bact_q;
    logic              hit_q;
    logic              hit_d;
    logic [CNTW-1:0]   hold_cnt_q, hold_cnt_d;
    logic              slow_req_q, slow_req_d;
    logic              slow_wait_q, slow_wait_d;
    logic              slow_gate_q, slow_gate_d;
    logic [CNTW-1:0]   hold_load;

    // Decode is taken on the first cycle of a bus cycle only and registered,
    // so the scheduler acts one edge later and ignores later enable changes.
    assign hit_d = BACT & ~bact_q &
                   ((IACKCS & SlowIACK) | (VIACS  & SlowVIA)  |
                    (IWMCS  & SlowIWM)  | (SCCCS  & SlowSCC)  |
                    (SCSICS & SlowSCSI) | (SndCSWR & SlowSnd));

    assign hold_load = {{(CNTW-4){1'b0}}, SlowTimeout} << HOLD_SHIFT;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            ST_FAST: begin
                if (hit_q) begin
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                // BACT dropping here is left for ACCESS to notice.
                if (SlowAck) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!BACT) begin
                    if (SlowTimeout == 4'd0) begin
                        state_d    = ST_FAST;
                        hold_cnt_d = '0;
                    end else begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = hold_load;
                    end
                end
            end
            ST_HOLD: begin
                // A new slow access takes priority over the final tick.
                if (hit_q) begin
                    state_d    = SlowAck ? ST_ACCESS : ST_SYNC;
                    hold_cnt_d = '0;
                end else if (TimeoutTick) begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                    if (hold_cnt_q == {{(CNTW-1){1'b0}}, 1'b1}) begin
                        state_d = ST_FAST;
                    end
                end
            end
            default: begin
                state_d    = ST_FAST;
                hold_cnt_d = '0;
            end
        endcase
    end

    // Outputs are registered copies of decodes of the next state.
    always_comb begin
        slow_req_d  = (state_d != ST_FAST);
        slow_wait_d = (state_d == ST_SYNC);
        slow_gate_d = SlowClockGate & SlowAck &
                      ((state_d == ST_ACCESS) | (state_d == ST_HOLD));
    end

    always_ff @(posedge CLK or negedge nPOR) begin
        if (!nPOR) begin
            state_q     <= ST_FAST;
            bact_q      <= 1'b0;
            hit_q       <= 1'b0;
            hold_cnt_q  <= '0;
            slow_req_q  <= 1'b0;
            slow_wait_q <= 1'b0;
            slow_gate_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bact_q      <= BACT;
            hit_q       <= hit_d;
            hold_cnt_q  <= hold_cnt_d;
            slow_req_q  <= slow_req_d;
            slow_wait_q <= slow_wait_d;
            slow_gate_q <= slow_gate_d;
        end
    end

    assign SlowReq  = slow_req_q;
    assign SlowWait = slow_wait_q;
    assign SlowGate = slow_gate_q;
    assign HoldCnt  = hold_cnt_q;

endmodule

// File: doc/slow_sched.md
# slow_sched

Sequences the accelerator's drop to native-speed bus timing around accesses to slow peripherals. It decodes each new bus cycle against the per-device slow-enable bits and requests the slow clock from the clock-switch logic, stalling the cycle until the switch is acknowledged. After the access it holds slow mode for a programmable tick count. It sits between the slow-settings register bank, the address decode, and the clock-switch/DTACK logic.

## Interface
Parameters:
- HOLD_SHIFT, 4: left shift applied to SlowTimeout to form the hold count.
- CNTW, 8: hold counter width; must equal 4 + HOLD_SHIFT.

Ports:
- CLK  in  1  fast system clock; all state updates on rising edge.
- nPOR  in  1  reset; asynchronous, active-low.
- BACT  in  1  bus cycle active; high from cycle start to end.
- IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCSWR  in  1 each  device selects, valid while BACT high.
- SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd  in  1 each  per-device slow enables.
- SlowClockGate  in  1  permits fast-clock gating while slow.
- SlowTimeout  in  4  hold length, units of 2^HOLD_SHIFT ticks; 0 means no hold.
- TimeoutTick  in  1  one-CLK pulse from the free-running timebase.
- SlowAck  in  1  clock switch reports slow clock in effect.
- SlowReq  out  1  request slow clock.
- SlowWait  out  1  stall the current bus cycle (hold off DTACK).
- SlowGate  out  1  gate the fast clock.
- HoldCnt  out  CNTW  remaining hold ticks; debug only.

## Operation
- BACTr: BACT registered. start = BACT & !BACTr.
- hit = start & OR of (xCS & Slowx) over the six device pairs.
- States: FAST, SYNC, ACCESS, HOLD. All outputs are registered, derived from the next state.
- FAST:
  - SlowReq=0.
  - On hit: go to SYNC.
- SYNC:
  - SlowReq=1, SlowWait=1.
  - When SlowAck=1 is sampled: go to ACCESS, with SlowWait=0 from the same edge.
  - BACT dropping in SYNC is ignored; ACCESS handles it.
- ACCESS:
  - SlowReq=1.
  - On BACT=0 with SlowTimeout=0: go to FAST.
  - On BACT=0 with SlowTimeout≠0: load HoldCnt = SlowTimeout<<HOLD_SHIFT and go to HOLD.
- HOLD:
  - SlowReq=1.
  - Each TimeoutTick decrements HoldCnt.
  - Tick with HoldCnt=1: go to FAST, HoldCnt=0.
  - hit with SlowAck=1: go to ACCESS. hit with SlowAck=0: go to SYNC.
  - A non-hit start keeps counting.
- Simultaneous hit and final tick in HOLD: hit wins, state leaves HOLD, no drop to FAST.
- SlowTimeout is sampled only at load. Changes during HOLD have no effect until the next load.
- Enable bits are sampled on the start cycle only.
- SlowGate = SlowClockGate & SlowAck & (next state ∈ {ACCESS, HOLD}).
- Release has no handshake. SlowReq drops and the clock switch returns to fast on its own.

## Timing
- Reset values: state FAST, SlowReq=0, SlowWait=0, SlowGate=0, HoldCnt=0, BACTr=0.
- Reset asserted mid-operation forces these values immediately, with no waiting for CLK.
- Latency: BACT is first sampled high at edge N.
  - SlowReq and SlowWait rise after edge N+1.
  - With SlowAck already high, SlowWait lasts exactly one cycle.
- SlowWait falls after the first edge at which SlowAck=1 is sampled in SYNC.
- ACCESS to FAST/HOLD happens one edge after BACT is sampled low.
- Hold duration is SlowTimeout·2^HOLD_SHIFT TimeoutTick pulses. Max 15·16=240 at defaults, so HoldCnt never wraps.
- A TimeoutTick at the load edge is not counted.

## Test plan
- Reset: assert nPOR=0 mid-HOLD with HoldCnt=0x25 -> all outputs 0 asynchronously; after release, FAST with HoldCnt=0.
- VIA hit, SlowVIA=1, SlowAck tied high -> SlowReq rises at N+1, SlowWait high exactly one cycle; SlowTimeout=3 -> HOLD for 48 ticks, then SlowReq=0.
- Disabled device: SCCCS=1, SlowSCC=0 -> outputs stay 0 throughout the cycle.
- Ack delay: SlowAck rises 5 cycles after SlowReq -> SlowWait high 5 cycles, then 0; SlowClockGate=1 -> SlowGate=1 from the edge after ACCESS is entered.
- SlowTimeout=0, IWM hit -> SlowReq drops one cycle after BACT falls; HoldCnt stays 0.
- In HOLD with HoldCnt=1, IWM hit and TimeoutTick on the same edge -> ACCESS, SlowReq stays 1; a later SlowTimeout change to 1 before the access ends reloads 16.
